// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1W1R SRAM.
package sram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int LANE_W    = 8;
    // Widest configuration the merge helper supports.
    localparam int MAX_LANES = 64;
    localparam int MAX_W     = LANE_W * MAX_LANES + 1;

    // Masked merge of a new word over an old word. Lanes below nlanes take
    // new_word where mask is set; the spare bit sits directly above the top
    // lane and takes new_word when spare_en is set. Shared by the array
    // write path and the read bypass so both always agree.
    function automatic logic [MAX_W-1:0] merge_lanes(
        input logic [MAX_W-1:0]     old_word,
        input logic [MAX_W-1:0]     new_word,
        input logic [MAX_LANES-1:0] mask,
        input logic                 spare_en,
        input int                   nlanes
    );
        logic [MAX_W-1:0] bit_en;
        bit_en = '0;
        for (int k = 0; k < MAX_LANES; k++) begin
            if (k < nlanes && mask[k]) begin
                bit_en[LANE_W*k +: LANE_W] = '1;
            end
        end
        bit_en = bit_en | (MAX_W'(spare_en) << (LANE_W * nlanes));
        return (old_word & ~bit_en) | (new_word & bit_en);
    endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// Init/run sequencing: zero-fills the array after reset, then hands the
// array write port over to the user write interface.
module sram_init_ctrl
    import sram_pkg::*;
#(
    parameter int BYTE_COUNT = 5,
    parameter int ADDR_WIDTH = 9,
    parameter int SPARE_EN   = 1,
    parameter int INIT_ZERO  = 1,
    parameter int DATA_WIDTH = LANE_W * BYTE_COUNT + SPARE_EN
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [BYTE_COUNT-1:0] wr_mask_i,
    input  logic                  wr_spare_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  ready_o,
    output logic                  arr_we_o,
    output logic [ADDR_WIDTH-1:0] arr_addr_o,
    output logic [BYTE_COUNT-1:0] arr_mask_o,
    output logic                  arr_spare_o,
    output logic [DATA_WIDTH-1:0] arr_data_o
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic                  r_ready;

    // State, fill counter and ready flag; ready follows the next state so it
    // rises on the same edge that writes the last init word.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= (INIT_ZERO != 0) ? INIT : RUN;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == RUN);
        end
    end

    // Next state and array-port mux; nothing reaches the array while rst_i
    // is low so reset itself never alters memory contents.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        arr_we_o    = 1'b0;
        arr_addr_o  = wr_addr_i;
        arr_mask_o  = wr_mask_i;
        arr_spare_o = (SPARE_EN != 0) && wr_spare_i;
        arr_data_o  = wr_data_i;
        case (r_state)
            INIT: begin
                arr_we_o    = rst_i;
                arr_addr_o  = r_cnt;
                arr_mask_o  = '1;
                arr_spare_o = (SPARE_EN != 0);
                arr_data_o  = '0;
                w_cnt_nxt   = r_cnt + 1'b1;
                if (&r_cnt) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                arr_we_o = rst_i && r_ready && wr_en_i;
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    assign ready_o = r_ready;

endmodule

// File: rtl/sram_1w1r_param.sv
// Simple-dual-port SRAM: one masked write port, one read port with a
// single-cycle latency, post-reset zero fill and optional write-first bypass.
module sram_1w1r_param
    import sram_pkg::*;
#(
    parameter int  BYTE_COUNT = 5,
    parameter int  ADDR_WIDTH = 9,
    parameter int  SPARE_EN   = 1,
    parameter int  INIT_ZERO  = 1,
    parameter int  BYPASS_EN  = 1,
    localparam int DATA_WIDTH = LANE_W * BYTE_COUNT + SPARE_EN,
    localparam int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  ready_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [BYTE_COUNT-1:0] wr_mask_i,
    input  logic                  wr_spare_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o
);

    if (BYTE_COUNT < 1 || BYTE_COUNT > MAX_LANES || ADDR_WIDTH < 1) begin : g_bad_params
        $error("sram_1w1r_param: BYTE_COUNT must be 1..%0d and ADDR_WIDTH >= 1", MAX_LANES);
    end

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic                  w_ready;
    logic                  w_arr_we;
    logic [ADDR_WIDTH-1:0] w_arr_addr;
    logic [BYTE_COUNT-1:0] w_arr_mask;
    logic                  w_arr_spare;
    logic [DATA_WIDTH-1:0] w_arr_data;
    logic [DATA_WIDTH-1:0] w_wr_merged;
    logic                  w_rd_acc;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] r_rd_data_p1;
    logic                  r_rd_vld_p1;

    sram_init_ctrl #(
        .BYTE_COUNT (BYTE_COUNT),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SPARE_EN   (SPARE_EN),
        .INIT_ZERO  (INIT_ZERO),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_init_ctrl (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_mask_i   (wr_mask_i),
        .wr_spare_i  (wr_spare_i),
        .wr_data_i   (wr_data_i),
        .ready_o     (w_ready),
        .arr_we_o    (w_arr_we),
        .arr_addr_o  (w_arr_addr),
        .arr_mask_o  (w_arr_mask),
        .arr_spare_o (w_arr_spare),
        .arr_data_o  (w_arr_data)
    );

    // Merged word is exactly what the write stores, so it doubles as the
    // write-first bypass value on a same-address collision.
    assign w_wr_merged = DATA_WIDTH'(merge_lanes(MAX_W'(r_mem[w_arr_addr]),
                                                 MAX_W'(w_arr_data),
                                                 MAX_LANES'(w_arr_mask),
                                                 w_arr_spare,
                                                 BYTE_COUNT));

    assign w_rd_acc  = w_ready && rd_en_i;
    assign w_collide = w_arr_we && (w_arr_addr == rd_addr_i);
    assign w_rd_word = ((BYPASS_EN != 0) && w_collide) ? w_wr_merged : r_mem[rd_addr_i];

    // Array write port (init fill or masked user write).
    always_ff @(posedge clk_i) begin
        if (w_arr_we) begin
            r_mem[w_arr_addr] <= w_wr_merged;
        end
    end

    // Read stage p0 -> p1: capture data on an accepted read, hold otherwise.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_rd_vld_p1  <= 1'b0;
            r_rd_data_p1 <= '0;
        end else begin
            r_rd_vld_p1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data_p1 <= w_rd_word;
            end
        end
    end

    assign ready_o    = w_ready;
    assign rd_data_o  = r_rd_data_p1;
    assign rd_valid_o = r_rd_vld_p1;

endmodule

// File: tb/tb_sram_1w1r_param.sv
// Directed bench: default build, a read-first build sharing its inputs, and a
// 32-bit no-init build. Read expectations go through a scoreboard queue.
module tb_sram_1w1r_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wr_en, wr_spare, rd_en;
    logic [8:0]  wr_addr, rd_addr;
    logic [4:0]  wr_mask;
    logic [40:0] wr_data;
    logic        ready_a, vld_a, ready_b, vld_b;
    logic [40:0] rdat_a, rdat_b;

    logic        nz_wr_en, nz_rd_en, nz_ready, nz_vld, nz_spare;
    logic [3:0]  nz_wr_addr, nz_rd_addr, nz_wr_mask;
    logic [31:0] nz_wr_data, nz_rdat;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc;
    int nv;

    logic [40:0] q_a [$];
    logic [40:0] q_b [$];
    string       q_tag [$];

    sram_1w1r_param u_dut_a (
        .clk_i(clk), .rst_i(rst_n), .ready_o(ready_a),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_mask_i(wr_mask),
        .wr_spare_i(wr_spare), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rdat_a), .rd_valid_o(vld_a)
    );

    sram_1w1r_param #(.BYPASS_EN(0)) u_dut_b (
        .clk_i(clk), .rst_i(rst_n), .ready_o(ready_b),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_mask_i(wr_mask),
        .wr_spare_i(wr_spare), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rdat_b), .rd_valid_o(vld_b)
    );

    sram_1w1r_param #(.BYTE_COUNT(4), .ADDR_WIDTH(4), .SPARE_EN(0), .INIT_ZERO(0)) u_dut_nz (
        .clk_i(clk), .rst_i(rst_n), .ready_o(nz_ready),
        .wr_en_i(nz_wr_en), .wr_addr_i(nz_wr_addr), .wr_mask_i(nz_wr_mask),
        .wr_spare_i(nz_spare), .wr_data_i(nz_wr_data),
        .rd_en_i(nz_rd_en), .rd_addr_i(nz_rd_addr),
        .rd_data_o(nz_rdat), .rd_valid_o(nz_vld)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_wr(input logic [8:0] a, input logic [40:0] d,
                            input logic [4:0] m, input logic s);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m; wr_spare = s;
    endtask

    task automatic push_rd(input logic [8:0] a, input logic [40:0] ea,
                           input logic [40:0] eb, input string tag);
        rd_en = 1'b1; rd_addr = a;
        q_a.push_back(ea); q_b.push_back(eb); q_tag.push_back(tag);
    endtask

    // One clock of the shared interface: sample just after the edge, retire a
    // pending read from the scoreboard, then drop the requests.
    task automatic step();
        string       t;
        logic [40:0] ea, eb;
        @(posedge clk); #1;
        if (q_a.size() > 0) begin
            t  = q_tag.pop_front();
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            check({t, "_vld_a"}, 64'(vld_a), 64'(1));
            check({t, "_vld_b"}, 64'(vld_b), 64'(1));
            check({t, "_data_a"}, 64'(rdat_a), 64'(ea));
            check({t, "_data_b"}, 64'(rdat_b), 64'(eb));
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_spare = 1'b0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        nz_wr_en = 1'b0; nz_rd_en = 1'b0; nz_spare = 1'b0;
        nz_wr_addr = '0; nz_rd_addr = '0; nz_wr_mask = '0; nz_wr_data = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_a", 64'(ready_a), 64'(0));
        check("rst_vld_a", 64'(vld_a), 64'(0));
        check("rst_data_a", 64'(rdat_a), 64'(0));
        check("rst_ready_nz", 64'(nz_ready), 64'(0));

        // Release reset and time the zero-fill.
        @(negedge clk); rst_n = 1'b1;
        cyc = 0;
        while (!ready_a && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) check("nz_ready_1cyc", 64'(nz_ready), 64'(1));
        end
        check("init_len_a", 64'(cyc), 64'(512));
        check("init_ready_b", 64'(ready_b), 64'(1));

        @(negedge clk); push_rd(9'h1FF, 41'h0, 41'h0, "rd_1ff"); step();

        @(negedge clk); drive_wr(9'd5, 41'h1_AB_CD_EF_12_34, 5'b11111, 1'b1); step();
        @(negedge clk); drive_wr(9'd5, 41'h0_FF_FF_FF_FF_FF, 5'b00101, 1'b0); step();
        @(negedge clk); push_rd(9'd5, 41'h1_AB_CD_FF_12_FF, 41'h1_AB_CD_FF_12_FF, "rd_merge"); step();

        @(negedge clk); drive_wr(9'd7, 41'h0_AA_AA_AA_AA_AA, 5'b11111, 1'b0); step();
        @(negedge clk);
        drive_wr(9'd7, 41'h0_00_11_22_33_44, 5'b00011, 1'b0);
        push_rd(9'd7, 41'h0_AA_AA_AA_33_44, 41'h0_AA_AA_AA_AA_AA, "collide7");
        step();
        @(negedge clk); push_rd(9'd7, 41'h0_AA_AA_AA_33_44, 41'h0_AA_AA_AA_33_44, "after7"); step();

        @(negedge clk);
        drive_wr(9'd9, 41'h1_00_00_00_00_00, 5'b00000, 1'b1);
        push_rd(9'd9, 41'h1_00_00_00_00_00, 41'h0, "spare_byp");
        step();

        @(negedge clk); drive_wr(9'd5, 41'h0, 5'b00000, 1'b0); step();
        @(negedge clk); push_rd(9'd5, 41'h1_AB_CD_FF_12_FF, 41'h1_AB_CD_FF_12_FF, "noop_wr"); step();

        @(negedge clk);
        drive_wr(9'd10, 41'h0_55_55_55_55_55, 5'b11111, 1'b0);
        push_rd(9'd5, 41'h1_AB_CD_FF_12_FF, 41'h1_AB_CD_FF_12_FF, "indep");
        step();
        @(negedge clk); push_rd(9'd10, 41'h0_55_55_55_55_55, 41'h0_55_55_55_55_55, "rd10"); step();

        @(negedge clk); drive_wr(9'd3, 41'h0_01_02_03_04_05, 5'b11111, 1'b0); step();
        @(negedge clk); push_rd(9'd3, 41'h0_01_02_03_04_05, 41'h0_01_02_03_04_05, "rd3"); step();
        repeat (4) begin
            @(posedge clk); #1;
            check("idle_vld", 64'(vld_a), 64'(0));
            check("idle_hold", 64'(rdat_a), 64'h0_01_02_03_04_05);
        end

        // 32-bit build without zero-fill.
        @(negedge clk);
        nz_wr_en = 1'b1; nz_wr_addr = 4'd0; nz_wr_mask = 4'hF; nz_wr_data = 32'hDEADBEEF;
        @(posedge clk); #1; nz_wr_en = 1'b0;
        @(negedge clk); nz_rd_en = 1'b1; nz_rd_addr = 4'd0;
        @(posedge clk); #1; nz_rd_en = 1'b0;
        check("nz_vld", 64'(nz_vld), 64'(1));
        check("nz_data", 64'(nz_rdat), 64'hDEADBEEF);
        @(negedge clk);
        nz_wr_en = 1'b1; nz_wr_mask = 4'b0001; nz_wr_data = 32'h0;
        @(posedge clk); #1; nz_wr_en = 1'b0;
        @(negedge clk); nz_rd_en = 1'b1;
        @(posedge clk); #1; nz_rd_en = 1'b0;
        check("nz_lane0", 64'(nz_rdat), 64'hDEADBE00);

        // Reset partway through a fresh fill, then hold requests during INIT.
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("mid_init_ready", 64'(ready_a), 64'(0));
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("rerst_ready", 64'(ready_a), 64'(0));
        check("rerst_vld", 64'(vld_a), 64'(0));
        check("rerst_data", 64'(rdat_a), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        drive_wr(9'd5, 41'h1_FF_FF_FF_FF_FF, 5'b11111, 1'b1);
        rd_en = 1'b1; rd_addr = 9'd5;
        cyc = 0; nv = 0;
        while (!ready_a && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            if (vld_a) nv++;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("reinit_len", 64'(cyc), 64'(512));
        check("reinit_no_vld", 64'(nv), 64'(0));

        @(negedge clk); push_rd(9'd5, 41'h0, 41'h0, "zero5"); step();
        @(negedge clk); push_rd(9'd7, 41'h0, 41'h0, "zero7"); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
